// File: rtl/descrambler_unit_if.sv
// Frame handshake and serial data bundle between a frame source and the descrambler.
interface descrambler_unit_if;
  logic        request;
  logic [11:0] length;
  logic        data_in;
  logic        data_out;
  logic        ready;
  logic        done;
  logic        abort;

  modport master (
    output request, length, data_in,
    input  data_out, ready, done, abort
  );

  modport slave (
    input  request, length, data_in,
    output data_out, ready, done, abort
  );
endinterface

// File: rtl/descrambler_unit.sv
// Additive x^7+x^4+1 serial descrambler with frame control (IDLE/RUN/DONE).
// The LFSR is reloaded with Seed at every frame start; all outputs are registered.
module descrambler_unit #(
  parameter logic [6:0] Seed = 7'h7F
) (
  input logic          clk,
  input logic          reset,
  descrambler_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [6:0]  lfsr_q;
  logic [11:0] remaining_q;
  logic        data_out_q;
  logic        ready_q;
  logic        done_q;
  logic        abort_q;
  logic        key;

  assign key = lfsr_q[6] ^ lfsr_q[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      lfsr_q      <= Seed;
      remaining_q <= '0;
      data_out_q  <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ready_q    <= 1'b0;
          done_q     <= 1'b0;
          data_out_q <= 1'b0;
          if (bus.request) begin
            if (bus.length != '0) begin
              state_q     <= StRun;
              remaining_q <= bus.length;
              lfsr_q      <= Seed;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (!bus.request) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            data_out_q <= 1'b0;
            abort_q    <= 1'b1;
          end else begin
            data_out_q  <= bus.data_in ^ key;
            lfsr_q      <= {lfsr_q[5:0], key};
            ready_q     <= 1'b1;
            remaining_q <= remaining_q - 12'd1;
            if (remaining_q == 12'd1) state_q <= StDone;
          end
        end
        StDone: begin
          // Last bit stays visible with ready for its one cycle; done follows it.
          ready_q <= 1'b0;
          if (bus.request) begin
            done_q <= 1'b1;
          end else begin
            state_q    <= StIdle;
            done_q     <= 1'b0;
            data_out_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.abort    = abort_q;

endmodule

// File: tb/tb_descrambler_unit.sv
// Self-checking bench: keystream from the recurrence k[n] = k[n-7] ^ k[n-4], a frame-level
// reference model checked every cycle, plus directed literal checks and random frames.
module tb_descrambler_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;

  descrambler_unit_if bus ();

  descrambler_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit ks[4096];
  bit seq[4103];
  bit got[$];
  bit sent[$];
  logic [7:0] pat = 8'b00001110;

  // Reference model state: 0 waiting for request, 1 streaming, 2 complete
  int   m_phase = 0;
  int   m_len   = 0;
  int   m_pos   = 0;
  logic e_out, e_rdy, e_done, e_abort;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function void step_model(input logic rst, input logic req, input logic [11:0] len,
                           input logic din);
    if (rst) begin
      m_phase = 0;
      e_out = 0; e_rdy = 0; e_done = 0; e_abort = 0;
      return;
    end
    e_abort = 0;
    case (m_phase)
      0: begin
        e_rdy = 0; e_done = 0; e_out = 0;
        if (req) begin
          if (len == 0) begin
            m_phase = 2;
            e_done  = 1;
          end else begin
            m_phase = 1;
            m_len   = int'(len);
            m_pos   = 0;
          end
        end
      end
      1: begin
        if (!req) begin
          m_phase = 0;
          e_abort = 1; e_rdy = 0; e_out = 0;
        end else begin
          e_out = din ^ ks[m_pos];
          e_rdy = 1;
          m_pos++;
          if (m_pos == m_len) m_phase = 2;
        end
      end
      default: begin
        e_rdy = 0;
        if (req) e_done = 1;
        else begin
          m_phase = 0;
          e_done  = 0;
          e_out   = 0;
        end
      end
    endcase
  endfunction

  // Keystream: seed bits occupy seq[0..6] (oldest first), then the recurrence.
  initial begin
    logic [6:0] seed;
    seed = 7'h7F;
    for (int j = 0; j < 7; j++) seq[j] = seed[6-j];
    for (int i = 0; i < 4096; i++) begin
      seq[i+7] = seq[i] ^ seq[i+3];
      ks[i]    = seq[i+7];
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(posedge clk);
      step_model(reset, bus.request, bus.length, bus.data_in);
      #1;
      chk("cyc_data_out", bus.data_out, e_out);
      chk("cyc_ready", bus.ready, e_rdy);
      chk("cyc_done", bus.done, e_done);
      chk("cyc_abort", bus.abort, e_abort);
    end
  end

  // Starts a frame and streams bits until done or abort. drop_after >= 0 drops request
  // after that many ready cycles. Collected outputs land in got, payload bits in sent.
  task automatic run_frame(input int len, input int drop_after, input bit zero_data,
                           input bit loopback, output int nrdy);
    int budget;
    bit payload;
    got.delete();
    sent.delete();
    nrdy = 0;
    bus.request = 1'b1;
    bus.length  = 12'(len);
    bus.data_in = 1'b0;
    @(negedge clk);
    budget = len + 10;
    while (!(bus.done === 1'b1 || bus.abort === 1'b1)) begin
      if (budget == 0) begin
        total++;
        bad++;
        $display("FAIL frame_timeout: len=%0d ready_seen=%0d required done or abort", len, nrdy);
        break;
      end
      budget--;
      if (drop_after >= 0 && nrdy == drop_after) bus.request = 1'b0;
      payload = zero_data ? 1'b0 : 1'($urandom_range(0, 1));
      bus.data_in = loopback ? (payload ^ ks[nrdy]) : payload;
      if ($urandom_range(0, 3) == 0) bus.length = 12'($urandom_range(0, 4095));
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        got.push_back(bus.data_out);
        sent.push_back(payload);
        nrdy++;
      end
    end
  endtask

  task automatic end_frame();
    bus.request = 1'b0;
    @(negedge clk);
    chk("done_clears", bus.done, 1'b0);
  endtask

  initial begin
    int n;
    int miss;
    int len;
    int drop;
    bus.request = 1'b0;
    bus.length  = '0;
    bus.data_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_out", bus.data_out, 1'b0);
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_abort", bus.abort, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) chk("keystream_pin", ks[i], pat[7-i]);

    // Zero input reveals the raw keystream
    run_frame(8, -1, 1'b1, 1'b0, n);
    chk("zero8_count", n, 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("zero8_bit", got[i], pat[7-i]);
    chk("zero8_done", bus.done, 1'b1);
    chk("zero8_ready_low", bus.ready, 1'b0);
    end_frame();

    // Zero-length frame
    @(negedge clk);
    run_frame(0, -1, 1'b1, 1'b0, n);
    chk("len0_count", n, 0);
    chk("len0_done", bus.done, 1'b1);
    end_frame();

    // Mid-frame drop
    run_frame(20, 5, 1'b0, 1'b0, n);
    chk("abort_count", n, 5);
    chk("abort_pulse", bus.abort, 1'b1);
    chk("abort_ready", bus.ready, 1'b0);
    @(negedge clk);
    chk("abort_one_cycle", bus.abort, 1'b0);
    chk("abort_idle_ready", bus.ready, 1'b0);

    // Reset mid-frame, then restart with request still high
    bus.request = 1'b1;
    bus.length  = 12'd8;
    bus.data_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_ready", bus.ready, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_data_out", bus.data_out, 1'b0);
    chk("midrst_ready", bus.ready, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_abort", bus.abort, 1'b0);
    reset = 1'b0;
    run_frame(8, -1, 1'b1, 1'b0, n);
    chk("rerun_count", n, 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("rerun_bit", got[i], pat[7-i]);

    // Hold request high in DONE
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_done", bus.done, 1'b1);
      chk("hold_no_ready", bus.ready, 1'b0);
    end
    end_frame();

    // Loopback through a matching scrambler
    run_frame(100, -1, 1'b0, 1'b1, n);
    chk("loop_count", n, 100);
    miss = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] != sent[i]) miss++;
    chk("loop_bits_wrong", miss, 0);
    end_frame();

    // Longest frame, no counter wrap
    run_frame(4095, -1, 1'b0, 1'b0, n);
    chk("max_len_count", n, 4095);
    end_frame();

    // Random frames with random drops and gaps
    for (int f = 0; f < 40; f++) begin
      len  = $urandom_range(0, 70);
      drop = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_frame(len, drop, 1'b0, 1'($urandom_range(0, 1)), n);
      if (drop >= 0) begin
        chk("rnd_abort_count", n, drop);
      end else begin
        chk("rnd_count", n, len);
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end_frame();
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
